fifo_r1_w16_64: RTL
===================

Name: fifo_r1_w16_64

Overview:
- Serial-to-parallel receive buffer for ADC conversion data.
- Captures a 1-bit serial stream, one bit per enabled clock, assembles WIDTH-bit words and stores them in an internal DEPTH-word FIFO for the host-side reader.
- Single clock domain. Sits between the ADC serial data output and the host readout pipe, as the return path of the transmit-side serializing FIFO.

Parameters:
- WIDTH, 16, word width in bits, and bits per assembled word.
- DEPTH, 64, FIFO depth in words. Must be a power of two.
- ADDR_W, 6, log2(DEPTH).
- MSB_FIRST, 1, 1 = first received bit lands in word bit WIDTH-1; 0 = first bit lands in bit 0.

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  serial data bit.
- wr_en  input  1  din is sampled on the clk rising edge when high.
- align  input  1  synchronous frame realign: discards any partial word.
- rd_en  input  1  pop one word; ignored while empty.
- dout  output  WIDTH  word read from the FIFO.
- valid  output  1  dout holds a freshly popped word (1-cycle pulse).
- full  output  1  FIFO holds DEPTH words.
- empty  output  1  FIFO holds 0 words.
- count  output  ADDR_W+1  number of words stored (0..DEPTH).
- overflow  output  1  sticky: an assembled word was dropped.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, rst=1), all cleared immediately:
  - bit counter, shift register, read/write pointers, count, dout = 0.
  - valid = 0, overflow = 0, full = 0, empty = 1.
- Deserializer:
  - bitcnt runs 0..WIDTH-1 and advances only on wr_en=1, wrapping to 0 after WIDTH-1.
  - MSB_FIRST=1: shift left, din enters bit 0. MSB_FIRST=0: shift right, din enters bit WIDTH-1.
  - Word completes on the wr_en cycle where bitcnt==WIDTH-1. The completed word includes that cycle's din bit.
  - The completed word is pushed into the FIFO at that same clock edge. No extra latency.
- align=1:
  - bitcnt forced to 0 and the partial word discarded. No push, even if bitcnt==WIDTH-1.
  - If wr_en=1 in the same cycle, din is taken as bit 0 of the new word, so bitcnt=1 after the edge.
- Push acceptance:
  - Accepted if count<DEPTH, or if count==DEPTH and a valid pop happens in the same cycle.
  - Otherwise the word is dropped, overflow is set, and pointers are unchanged. The deserializer keeps running, so the next word starts aligned.
- Pop:
  - rd_en=1 with empty=0 loads dout from mem[rd_ptr] at the edge. valid=1 for exactly that following cycle, and rd_ptr increments.
  - Read latency is 1 clock.
  - rd_en while empty: no change; dout holds its last value and valid=0.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push into an empty FIFO: the word is poppable the next cycle (empty deasserts one cycle after the push edge). No fall-through.
- Pointers: ADDR_W bits with natural wrap modulo DEPTH.
- Flags:
  - count, full and empty are registered and consistent with each other every cycle.
  - full = (count==DEPTH); empty = (count==0).
- overflow:
  - Cleared by rst or by clr_ovf.
  - If clr_ovf and a new drop occur in the same cycle, set wins.
- Reset mid-word or mid-read: everything is discarded. No partial word survives.

Test Plan:
- MSB_FIRST=1; shift in 0xA5C3 MSB first with wr_en=1 for 16 consecutive cycles; pop -> dout=0xA5C3, valid pulses 1 cycle, empty=1 after the pop, count 1->0.
- Send 8 bits, pulse align with wr_en=0, then send 16 bits of 0x1234 -> exactly one word stored and it reads 0x1234. Repeat with align and wr_en together (first bit included) -> same result.
- Push 64 words 0..63 with no reads -> full=1, count=64. Push word 64 -> overflow=1, count=64. Pop all -> 0..63 in order, empty=1.
- With full=1, complete a word in the same cycle as rd_en=1 -> no overflow, count stays 64, the new word is read last.
- Gapped wr_en (random idle cycles between bits) for 200 words with random reads -> output sequence matches the scoreboard, pointers wrap correctly, and count never exceeds 64.
- Assert rst at bit 7 of a word and with 5 words stored -> immediately count=0, empty=1, dout=0, overflow=0. The next 16 bits form a clean word.

Source files
------------

// File: rtl/fifo_r1_w16_64_if.sv
// Receive-buffer bus: serial input side, host readout side and status flags.
//   master : drives din/wr_en/align/rd_en/clr_ovf, observes dout/valid/flags
//   slave  : the buffer itself
interface fifo_r1_w16_64_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 6
);
  logic              din;
  logic              wr_en;
  logic              align;
  logic              rd_en;
  logic              clr_ovf;
  logic [WIDTH-1:0]  dout;
  logic              valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;

  modport master (
    output din, wr_en, align, rd_en, clr_ovf,
    input  dout, valid, full, empty, count, overflow
  );

  modport slave (
    input  din, wr_en, align, rd_en, clr_ovf,
    output dout, valid, full, empty, count, overflow
  );
endinterface

// File: rtl/fifo_r1_w16_64.sv
// Serial-to-parallel receive buffer: assembles WIDTH-bit words from a 1-bit
// stream (one bit per wr_en cycle) and queues them in a DEPTH-word FIFO.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus.din    : serial bit, sampled when bus.wr_en=1
//   bus.align  : drop the partial word, restart at bit 0
//   bus.rd_en  : pop one word (ignored while empty), 1-cycle read latency
//   bus.dout/valid : popped word and its 1-cycle strobe
//   bus.full/empty/count : registered occupancy
//   bus.overflow/clr_ovf : sticky word-dropped flag and its clear
module fifo_r1_w16_64 #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned ADDR_W    = 6,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  fifo_r1_w16_64_if.slave    bus
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned BCNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

  // Deserializer state
  logic [BCNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic [WIDTH-1:0]  shifted_c;
  logic [WIDTH-1:0]  first_c;
  logic              word_done_c;

  // FIFO state
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_c;
  logic              push_ok_c;
  logic              drop_c;

  // Registered outputs
  logic [WIDTH-1:0]  dout_q;
  logic              valid_q;
  logic              full_q;
  logic              empty_q;
  logic              ovf_q;

  // Shift-register candidates: regular shift, and a fresh word holding only din
  always_comb begin
    shifted_c = sreg_q;
    first_c   = '0;
    if (MSB_FIRST) begin
      shifted_c = {sreg_q[WIDTH-2:0], bus.din};
      first_c   = WIDTH'(bus.din);
    end else begin
      shifted_c = {bus.din, sreg_q[WIDTH-1:1]};
      first_c   = {bus.din, {(WIDTH-1){1'b0}}};
    end
  end

  // Deserializer next state; align overrides word completion
  always_comb begin
    bitcnt_d    = bitcnt_q;
    sreg_d      = sreg_q;
    word_done_c = 1'b0;
    if (bus.align) begin
      bitcnt_d = bus.wr_en ? BCNT_W'(1) : '0;
      sreg_d   = bus.wr_en ? first_c : '0;
    end else if (bus.wr_en) begin
      sreg_d = shifted_c;
      if (bitcnt_q == LAST_BIT) begin
        bitcnt_d    = '0;
        word_done_c = 1'b1;
      end else begin
        bitcnt_d = bitcnt_q + BCNT_W'(1);
      end
    end
  end

  // Push/pop decisions; a full FIFO still accepts a word when a pop frees a slot
  always_comb begin
    pop_c     = bus.rd_en && !empty_q;
    push_ok_c = word_done_c && (!full_q || pop_c);
    drop_c    = word_done_c && full_q && !pop_c;
    count_d   = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitcnt_q <= '0;
      sreg_q   <= '0;
    end else begin
      bitcnt_q <= bitcnt_d;
      sreg_q   <= sreg_d;
    end
  end

  // Storage array carries no reset; pointers/count define what is live
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem[wr_ptr_q] <= shifted_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push_ok_c) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        dout_q   <= mem[rd_ptr_q];
      end
      valid_q <= pop_c;
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_CNT);
      empty_q <= (count_d == '0);
    end
  end

  // Sticky overflow; a new drop wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (drop_c) begin
      ovf_q <= 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.valid    = valid_q;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;

endmodule
